// File: rtl/fifo_rd_stream_if.sv
// Downstream valid/ready stream carrying one data word per beat,
// plus a last-beat marker for packet framing.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer of the async FIFO. Issues FIFO reads, absorbs the
// one-cycle read latency in a 2-entry skid buffer and presents the words as
// a framed valid/ready stream at up to one word per cycle.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_rd_stream_if.master      m,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            occ;
  logic                  inflight;
  logic [15:0]           beat_cnt;
  logic                  pop;
  logic [1:0]            level_after;

  // Stream outputs come straight off the buffer head; data is zeroed when empty.
  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = m.m_valid ? mem[head] : '0;
  assign m.m_last  = m.m_valid & (beat_cnt == LAST_BEAT);
  assign busy      = (state != IDLE);

  assign pop = m.m_valid & m.m_ready;

  // Buffer level once this cycle's capture and pop settle. Looking at pop
  // combinationally lets a read issue in the same cycle a slot is freed,
  // which is what sustains one word per cycle.
  assign level_after = occ + 2'(inflight) - 2'(pop);

  assign fifo_rd_en = !rd_rst && (state == RUN) && !fifo_empty &&
                      (level_after < 2'd2);

  // Next-state logic for the fetch control FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = FLUSH;
      FLUSH: begin
        if (enable)                        state_nxt = RUN;
        else if (occ == 2'd0 && !inflight) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge rd_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rd_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Buffer pointers, occupancy and read-in-flight tracking.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) tail <= ~tail;
      if (pop)      head <= ~head;
      occ <= occ + 2'(inflight) - 2'(pop);
    end
  end

  // Capture the word returned by last cycle's accepted read.
  // NOTE: storage is not reset; m_data is masked by m_valid, so stale entries never reach the output.
  always_ff @(posedge rd_clk) begin
    if (inflight) mem[tail] <= fifo_data_out;
  end

  // Packet beat position and running count of delivered words.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      beat_cnt   <= 16'd0;
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 1'b1;
      beat_cnt   <= (beat_cnt == LAST_BEAT) ? 16'd0 : beat_cnt + 16'd1;
    end
  end

  // The read-issue rule must never let buffered plus in-flight words exceed two.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
    (3'(occ) + 3'(inflight)) <= 3'd2);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural FIFO read port feeds each DUT,
// stimulus pushes words into the FIFO model and the expected-data queue,
// and negedge monitors pop and compare whenever a beat is accepted.
module tb_fifo_rd_stream;

  localparam int PKT_A = 16;

  logic rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  // ---------------- DUT A: PKT_LEN=16, CNT_WIDTH=16 ----------------
  logic        rd_rst;
  logic        enable;
  logic        fifo_empty    = 1'b1;
  logic [7:0]  fifo_data_out = 8'h00;
  logic        fifo_rd_en;
  logic [15:0] word_count;
  logic        busy;
  fifo_rd_stream_if #(.DATA_WIDTH(8)) s_a ();

  fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(PKT_A), .CNT_WIDTH(16)) dut_a (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m             (s_a),
    .word_count    (word_count),
    .busy          (busy)
  );

  logic [7:0] fq_a[$];
  logic [7:0] exp_a[$];
  int         beat_a = 0;
  int         out_a = 0;
  logic       stall_a = 1'b0;
  logic [7:0] stall_data_a = 8'h00;
  logic [7:0] e_a;

  task automatic push_a(input logic [7:0] d);
    fq_a.push_back(d);
    exp_a.push_back(d);
  endtask

  // FIFO read port model A: data one cycle after an accepted read; empty flag registered.
  always @(posedge rd_clk) begin
    if (fifo_rd_en && !fifo_empty) fifo_data_out <= fq_a.pop_front();
    fifo_empty <= (fq_a.size() == 0);
  end

  // Words read from FIFO A but not yet delivered downstream.
  always @(posedge rd_clk) begin
    if (rd_rst) out_a <= 0;
    else out_a <= out_a + int'(fifo_rd_en && !fifo_empty) - int'(s_a.m_valid && s_a.m_ready);
  end

  // Monitor A: scoreboard compare, framing, stall stability, read headroom.
  always @(negedge rd_clk) begin
    if (rd_rst) begin
      beat_a  = 0;
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("a_stall_valid", 32'(s_a.m_valid), 32'd1);
        check("a_stall_data", 32'(s_a.m_data), 32'(stall_data_a));
      end
      if (s_a.m_valid && s_a.m_ready) begin
        if (exp_a.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL a_unexpected_beat: got 0x%0h, expected no beat", s_a.m_data);
        end else begin
          e_a = exp_a.pop_front();
          check("a_data", 32'(s_a.m_data), 32'(e_a));
          check("a_last", 32'(s_a.m_last), 32'(beat_a == PKT_A - 1));
          beat_a = (beat_a + 1) % PKT_A;
        end
      end
      if (fifo_rd_en)
        check("a_rd_room", 32'((out_a - int'(s_a.m_valid && s_a.m_ready)) < 2), 32'd1);
      stall_a      = s_a.m_valid && !s_a.m_ready;
      stall_data_a = s_a.m_data;
    end
  end

  // ---------------- DUT B: PKT_LEN=1, CNT_WIDTH=4 ----------------
  logic       rst_b;
  logic       enable_b;
  logic       empty_b = 1'b1;
  logic [7:0] data_b  = 8'h00;
  logic       rd_en_b;
  logic [3:0] wc_b;
  logic       busy_b;
  fifo_rd_stream_if #(.DATA_WIDTH(8)) s_b ();

  fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(1), .CNT_WIDTH(4)) dut_b (
    .rd_clk        (rd_clk),
    .rd_rst        (rst_b),
    .enable        (enable_b),
    .fifo_empty    (empty_b),
    .fifo_data_out (data_b),
    .fifo_rd_en    (rd_en_b),
    .m             (s_b),
    .word_count    (wc_b),
    .busy          (busy_b)
  );

  logic [7:0] fq_b[$];
  logic [7:0] exp_b[$];
  logic [7:0] e_b;

  // FIFO read port model B.
  always @(posedge rd_clk) begin
    if (rd_en_b && !empty_b) data_b <= fq_b.pop_front();
    empty_b <= (fq_b.size() == 0);
  end

  // Monitor B: every beat must carry m_last.
  always @(negedge rd_clk) begin
    if (!rst_b && s_b.m_valid && s_b.m_ready) begin
      if (exp_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_beat: got 0x%0h, expected no beat", s_b.m_data);
      end else begin
        e_b = exp_b.pop_front();
        check("b_data", 32'(s_b.m_data), 32'(e_b));
        check("b_last", 32'(s_b.m_last), 32'd1);
      end
    end
  end

  task automatic drain_a(input string name, input int bound);
    int i = 0;
    while (exp_a.size() != 0 && i < bound) begin
      tick();
      i++;
    end
    check(name, 32'(exp_a.size()), 32'd0);
  endtask

  initial begin
    rd_rst = 1'b1; enable = 1'b0; s_a.m_ready = 1'b0;
    rst_b  = 1'b1; enable_b = 1'b0; s_b.m_ready = 1'b0;
    tick(3);

    // Reset state
    check("rst_valid", 32'(s_a.m_valid), 32'd0);
    check("rst_last", 32'(s_a.m_last), 32'd0);
    check("rst_data", 32'(s_a.m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);

    // Full-rate packet: 0x00..0x0F with m_ready held high
    for (int i = 0; i < 16; i++) push_a(8'(i));
    rd_rst = 1'b0;
    tick(2);
    s_a.m_ready = 1'b1;
    enable = 1'b1;
    tick(); check("lat_edge1", 32'(s_a.m_valid), 32'd0);
    tick(); check("lat_edge2", 32'(s_a.m_valid), 32'd0);
    tick(); check("lat_edge3", 32'(s_a.m_valid), 32'd1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("no_bubble", 32'(s_a.m_valid), 32'd1);
    end
    tick();
    check("t1_valid_low", 32'(s_a.m_valid), 32'd0);
    check("t1_wc", 32'(word_count), 32'd16);
    check("t1_sb_empty", 32'(exp_a.size()), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);

    // Back-pressure: m_ready toggles every cycle
    s_a.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_a(8'(i));
    for (int i = 0; i < 200 && exp_a.size() != 0; i++) begin
      tick();
      s_a.m_ready = ~s_a.m_ready;
    end
    check("t2_drain", 32'(exp_a.size()), 32'd0);
    tick();
    check("t2_wc", 32'(word_count), 32'd32);
    check("t2_valid_low", 32'(s_a.m_valid), 32'd0);

    // FIFO runs dry mid-packet, then refills
    s_a.m_ready = 1'b1;
    push_a(8'h20); push_a(8'h21); push_a(8'h22);
    drain_a("t3_drain3", 20);
    tick(2);
    check("t3_dry_valid", 32'(s_a.m_valid), 32'd0);
    check("t3_dry_busy", 32'(busy), 32'd1);
    check("t3_wc3", 32'(word_count), 32'd35);
    push_a(8'h23); push_a(8'h24);
    drain_a("t3_drain2", 20);
    tick();
    check("t3_wc5", 32'(word_count), 32'd37);
    for (int i = 5; i < 16; i++) push_a(8'(8'h20 + i));
    drain_a("t3_drain_rest", 40);
    tick();
    check("t3_wc16", 32'(word_count), 32'd48);

    // Flush: buffer full and stalled, enable dropped
    s_a.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'(8'h30 + i));
    tick(6);
    check("t4_full_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t4_head", 32'(s_a.m_data), 32'h30);
    enable = 1'b0;
    tick();
    check("t4_flush_busy", 32'(busy), 32'd1);
    check("t4_flush_rd_en", 32'(fifo_rd_en), 32'd0);
    s_a.m_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) begin
      tick();
      check("t4_flush_no_read", 32'(fifo_rd_en), 32'd0);
    end
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_left_in_fifo", 32'(exp_a.size()), 32'd2);
    check("t4_valid_low", 32'(s_a.m_valid), 32'd0);
    check("t4_wc", 32'(word_count), 32'd50);

    // Reset with a full buffer: buffered words are lost
    s_a.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_a(8'(8'h40 + i));
    enable = 1'b1;
    tick(6);
    check("t5_head", 32'(s_a.m_data), 32'h32);
    check("t5_full_rd_en", 32'(fifo_rd_en), 32'd0);
    rd_rst = 1'b1;
    enable = 1'b0;
    exp_a = fq_a;
    tick();
    check("t5_rst_valid", 32'(s_a.m_valid), 32'd0);
    check("t5_rst_wc", 32'(word_count), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    rd_rst = 1'b0;
    tick(5);
    check("t5_stay_idle", 32'(busy), 32'd0);
    check("t5_idle_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t5_idle_valid", 32'(s_a.m_valid), 32'd0);
    s_a.m_ready = 1'b1;
    enable = 1'b1;
    drain_a("t5_drain", 60);
    tick();
    check("t5_wc", 32'(word_count), 32'd16);

    // Single-beat packets with a 4-bit wrapping counter
    for (int i = 0; i < 20; i++) begin
      fq_b.push_back(8'(8'h50 + i));
      exp_b.push_back(8'(8'h50 + i));
    end
    rst_b = 1'b0;
    tick(2);
    s_b.m_ready = 1'b1;
    enable_b = 1'b1;
    for (int i = 0; i < 100 && exp_b.size() != 0; i++) begin
      tick();
      check("b_wc_track", 32'(wc_b), 32'((20 - exp_b.size()) % 16));
    end
    check("b_drain", 32'(exp_b.size()), 32'd0);
    tick();
    check("b_wc_final", 32'(wc_b), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
